target_dispatcher: RTL and testbench
====================================

# target_dispatcher

Control-side counterpart to the target FSM. It decides when the next red bird launches and in which of the 8 lanes, using an LFSR and a randomised inter-spawn gap. It drives the `start`/`din` launch handshake and detects bullet hits against the live target's bounding box, raising `shot`. It also keeps the hit score. It sits between the game-level controller and one target instance, all in the 100 Hz game domain.

## Interface
- `SEED`, 16'hACE1: LFSR reset value. Must be non-zero.
- `GAP_MIN`, 50: minimum idle ticks between a target leaving the screen and the next launch.
- `GAP_RAND_BITS`, 5: the random gap extension is `lfsr[GAP_RAND_BITS+2:3]`, i.e. 0..31 ticks.
- `TW`, 34: target hitbox width in pixels.
- `TH`, 24: target hitbox height in pixels.

Ports:
- `clk_100Hz` in 1: game tick clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: game running. Low forces IDLE.
- `target_state` in 2: target FSM state. 0 = initial, 1 = flying, 2 = dying.
- `target_x` in 10: target left edge.
- `target_y` in 9: target top edge.
- `bullet_valid` in 1: a bullet is present this tick.
- `bullet_x` in 10: bullet point x.
- `bullet_y` in 9: bullet point y.
- `start` out 1: launch request to the target, registered.
- `din` out 3: lane index to the target, registered, held stable while `start`=1.
- `shot` out 1: hit pulse to the target, registered, one tick wide.
- `bullet_consume` out 1: one-tick pulse coincident with `shot`; tells the bullet owner to retire the bullet.
- `hit_count` out 8: saturating hit score.
- `miss_count` out 8: saturating count of escaped targets. See Configuration.

## Operation
- LFSR: 16-bit Galois, mask 16'hB400. Shifts every tick in all states and resets to `SEED`.
- States: IDLE, GAP, LAUNCH, TRACK.
- IDLE → GAP when `enable`=1. On entry, load `gap_cnt = GAP_MIN + lfsr[GAP_RAND_BITS+2:3]`.
- GAP: decrement `gap_cnt` each tick. When it reaches 0 and `target_state`==0, go to LAUNCH and latch `din <= lfsr[2:0]`, `start <= 1`.
  - If `target_state`!=0 at zero count, stay in GAP at 0 until it returns to 0.
- LAUNCH: hold `start`=1 and `din` constant. When `target_state`==1, set `start <= 0`, clear `hit_lock`, go to TRACK.
- TRACK: the hit condition is all of:
  - `bullet_valid`, `target_state`==1 and `!hit_lock`;
  - `target_x <= bullet_x < target_x+TW`, compared at 11 bits (no wrap);
  - `target_y <= bullet_y < target_y+TH`, compared at 10 bits.
- On a hit: `shot <= 1`, `bullet_consume <= 1`, `hit_lock <= 1`, `hit_count` increments and saturates at 255.
- `hit_lock` suppresses repeat hits while the target still reads flying for the tick after `shot`.
- TRACK → GAP (reload `gap_cnt`) when `target_state` returns to 0. If `hit_lock`=0 at that point, the target escaped: it counts as a miss.
- `enable`=0 from any state: next state IDLE. `start`, `shot` and `bullet_consume` go to 0. `din`, `hit_count` and `miss_count` hold.
- Counters clear only on reset.

## Timing
- Reset values: `start`=0, `din`=0, `shot`=0, `bullet_consume`=0, `hit_count`=0, `miss_count`=0, state IDLE, `lfsr`=`SEED`, `hit_lock`=0.
- Launch latency: `gap_cnt` reaches 0 at edge N, `start`/`din` are valid after N. The target goes flying at edge N+1, and `start` drops after edge N+2.
- Hit latency: hit inputs sampled at edge N, `shot` high between N and N+1. The target enters dying at edge N+1.
- `shot`/`bullet_consume` are never high for two consecutive ticks.
- Simultaneous events:
  - A hit on the same tick `target_state` returns to 0 is ignored: the state check fails, and it counts as a miss.
  - `enable` falling on a hit tick: disable wins, no `shot`.
- Async reset mid-LAUNCH drops `start` immediately, not waiting for the next edge.

## Configuration
- `TARGET_DISPATCH_MISS_CNT_EN` defined: `miss_count` increments (saturating at 255) on each TRACK→GAP exit with `hit_lock`=0.
- Macro undefined: `miss_count` is tied to 8'd0 and the miss-detection logic is removed.
- The port exists in both builds.

## Test plan
- Reset then `enable`=1 with `target_state`=0: `start` rises after exactly `GAP_MIN + lfsr[7:3]` + 1 ticks, with `din` equal to `lfsr[2:0]` at that tick. Check against a reference LFSR model seeded 16'hACE1.
- Handshake: hold `target_state`=0 for 5 ticks after `start`. `start` and `din` stay stable. Set `target_state`=1 and `start` drops next tick.
- Hit:
  - target at (300,128), bullet (300,128) valid: `shot`=1 for one tick and `hit_count` 0→1.
  - bullet (334,128): no `shot`.
  - bullet (333,151): `shot`.
- Lock: bullet held inside the box for 4 ticks with target still flying: exactly one `shot` and `hit_count`=1.
- Miss (macro on): the target goes 1→0 with no hit, so `miss_count`=1 and `hit_count` is unchanged. With the macro off, `miss_count` stays 0. 256 misses saturate at 255.
- Pull `rst_n` low mid-LAUNCH: `start`=0 asynchronously. Drop `enable` in TRACK: return to IDLE and the counters hold.

Source files
------------

// File: rtl/target_dispatcher.sv
// Spawn scheduler and hit detector for one target: random gap, random lane, bullet hitbox test, hit/miss score.
// Latency: start/din registered one edge after the gap expires; shot/bullet_consume registered one edge after the hit sample.
// No backpressure: start is held until the target reads flying. TARGET_DISPATCH_MISS_CNT_EN enables the miss counter.
module target_dispatcher #(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          GAP_MIN       = 50,
    parameter int          GAP_RAND_BITS = 5,
    parameter int          TW            = 34,
    parameter int          TH            = 24
) (
    input  logic       clk_100Hz,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] target_state,
    input  logic [9:0] target_x,
    input  logic [8:0] target_y,
    input  logic       bullet_valid,
    input  logic [9:0] bullet_x,
    input  logic [8:0] bullet_y,
    output logic       start,
    output logic [2:0] din,
    output logic       shot,
    output logic       bullet_consume,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count
);

    typedef enum logic [1:0] {IDLE, GAP, LAUNCH, TRACK} state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          GW        = 16;
    localparam logic [1:0]  TS_INIT   = 2'd0;
    localparam logic [1:0]  TS_FLY    = 2'd1;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            hit_lock_q, hit_lock_d;
    logic            start_q, start_d;
    logic [2:0]      din_q, din_d;
    logic            shot_q, shot_d;
    logic            consume_q, consume_d;
    logic [7:0]      hit_cnt_q, hit_cnt_d;

    logic [GW-1:0]   gap_reload;
    logic [10:0]     bx, tx, tx_end;
    logic [9:0]      by, ty, ty_end;
    logic            in_box, hit;

    assign gap_reload = GW'(GAP_MIN) + GW'(lfsr_q[GAP_RAND_BITS+2:3]);

    // Widened by one bit so a target near the right/bottom edge cannot wrap its box.
    assign bx     = {1'b0, bullet_x};
    assign tx     = {1'b0, target_x};
    assign tx_end = tx + 11'(TW);
    assign by     = {1'b0, bullet_y};
    assign ty     = {1'b0, target_y};
    assign ty_end = ty + 10'(TH);
    assign in_box = (bx >= tx) && (bx < tx_end) && (by >= ty) && (by < ty_end);
    assign hit    = bullet_valid && (target_state == TS_FLY) && !hit_lock_q && in_box;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        gap_cnt_d  = gap_cnt_q;
        hit_lock_d = hit_lock_q;
        start_d    = start_q;
        din_d      = din_q;
        shot_d     = 1'b0;
        consume_d  = 1'b0;
        hit_cnt_d  = hit_cnt_q;
        if (!enable) begin
            state_d = IDLE;
            start_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = GAP;
                    gap_cnt_d = gap_reload;
                end
                GAP: begin
                    // Launch on the edge the count lands on zero, or later once the target is back home.
                    if ((gap_cnt_q <= GW'(1)) && (target_state == TS_INIT)) begin
                        state_d   = LAUNCH;
                        gap_cnt_d = '0;
                        start_d   = 1'b1;
                        din_d     = lfsr_q[2:0];
                    end else if (gap_cnt_q != '0) begin
                        gap_cnt_d = gap_cnt_q - GW'(1);
                    end
                end
                LAUNCH: begin
                    if (target_state == TS_FLY) begin
                        state_d    = TRACK;
                        start_d    = 1'b0;
                        hit_lock_d = 1'b0;
                    end
                end
                TRACK: begin
                    if (target_state == TS_INIT) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_reload;
                    end else if (hit) begin
                        shot_d     = 1'b1;
                        consume_d  = 1'b1;
                        hit_lock_d = 1'b1;
                        if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            gap_cnt_q  <= '0;
            hit_lock_q <= 1'b0;
            start_q    <= 1'b0;
            din_q      <= 3'd0;
            shot_q     <= 1'b0;
            consume_q  <= 1'b0;
            hit_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            gap_cnt_q  <= gap_cnt_d;
            hit_lock_q <= hit_lock_d;
            start_q    <= start_d;
            din_q      <= din_d;
            shot_q     <= shot_d;
            consume_q  <= consume_d;
            hit_cnt_q  <= hit_cnt_d;
        end
    end

    assign start          = start_q;
    assign din            = din_q;
    assign shot           = shot_q;
    assign bullet_consume = consume_q;
    assign hit_count      = hit_cnt_q;

`ifdef TARGET_DISPATCH_MISS_CNT_EN
    logic       escape;
    logic [7:0] miss_cnt_q, miss_cnt_d;

    // A target that returns home without ever being hit escaped.
    assign escape = enable && (state_q == TRACK) && (target_state == TS_INIT) && !hit_lock_q;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (escape && (miss_cnt_q != 8'hFF)) miss_cnt_d = miss_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) miss_cnt_q <= 8'd0;
        else        miss_cnt_q <= miss_cnt_d;
    end

    assign miss_count = miss_cnt_q;
`else
    assign miss_count = 8'd0;
`endif

endmodule

// File: tb/tb_target_dispatcher.sv
// Scoreboard bench for target_dispatcher: reference LFSR predicts launch timing and lane, expected shots queued per bullet.
module tb_target_dispatcher;

    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          GAP_MIN = 50;
    localparam int          RB      = 5;

    logic       clk_100Hz = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] target_state = 2'd0;
    logic [9:0] target_x = 10'd300;
    logic [8:0] target_y = 9'd128;
    logic       bullet_valid = 1'b0;
    logic [9:0] bullet_x = 10'd0;
    logic [8:0] bullet_y = 9'd0;
    logic       start;
    logic [2:0] din;
    logic       shot;
    logic       bullet_consume;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    target_dispatcher dut (
        .clk_100Hz      (clk_100Hz),
        .rst_n          (rst_n),
        .enable         (enable),
        .target_state   (target_state),
        .target_x       (target_x),
        .target_y       (target_y),
        .bullet_valid   (bullet_valid),
        .bullet_x       (bullet_x),
        .bullet_y       (bullet_y),
        .start          (start),
        .din            (din),
        .shot           (shot),
        .bullet_consume (bullet_consume),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    typedef struct {
        int         wait_ticks;
        logic [2:0] din;
    } launch_exp_t;

    launch_exp_t launch_q[$];
    logic        shot_exp_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          exp_hits = 0;
    int          exp_miss = 0;
    logic [2:0]  cur_din = 3'd0;
    logic [15:0] lfsr_m;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference LFSR: at posedge+1 it holds the value the DUT will sample at the next edge.
    always @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) lfsr_m <= SEED;
        else        lfsr_m <= lfsr_next(lfsr_m);
    end

    task automatic tick();
        @(posedge clk_100Hz);
        #1;
    endtask

    // Call right after driving whatever makes the next edge enter GAP.
    task automatic push_gap_entry();
        launch_exp_t e;
        int          g;
        logic [15:0] v;
        g = GAP_MIN + int'(lfsr_m[RB+2:3]);
        v = lfsr_m;
        for (int i = 0; i < g; i++) v = lfsr_next(v);
        e.wait_ticks = g + 1;
        e.din        = v[2:0];
        launch_q.push_back(e);
    endtask

    task automatic sb_launch(input int pre);
        launch_exp_t e;
        int          k;
        e = launch_q.pop_front();
        k = pre;
        while (start !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        vec_cnt++;
        if (k !== e.wait_ticks) begin
            err_cnt++;
            $display("FAIL launch_latency: got %0d ticks, expected %0d", k, e.wait_ticks);
        end
        vec_cnt++;
        if (din !== e.din) begin
            err_cnt++;
            $display("FAIL launch_din: got %0d, expected %0d", din, e.din);
        end
        cur_din = e.din;
    endtask

    task automatic sb_shot(input string name);
        logic e;
        e = shot_exp_q.pop_front();
        vec_cnt++;
        if (shot !== e) begin
            err_cnt++;
            $display("FAIL %s shot: got %b, expected %b", name, shot, e);
        end
        vec_cnt++;
        if (bullet_consume !== e) begin
            err_cnt++;
            $display("FAIL %s consume: got %b, expected %b", name, bullet_consume, e);
        end
    endtask

    task automatic drive_bullet(input logic v, input logic [9:0] x, input logic [8:0] y);
        bullet_valid = v;
        bullet_x     = x;
        bullet_y     = y;
    endtask

    task automatic fly();
        target_state = 2'd1;
        tick();
        vec_cnt++;
        if (start !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_drop: got %b, expected 0", start);
        end
    endtask

    task automatic exit_target(input logic dying);
        drive_bullet(1'b0, 10'd0, 9'd0);
        if (dying) begin
            target_state = 2'd2;
            tick();
        end
        target_state = 2'd0;
        push_gap_entry();
    endtask

    task automatic bump_miss();
`ifdef TARGET_DISPATCH_MISS_CNT_EN
        if (exp_miss < 255) exp_miss++;
`endif
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        vec_cnt += 6;
        if (start !== 1'b0)          begin err_cnt++; $display("FAIL reset_start: got %b, expected 0", start); end
        if (din !== 3'd0)            begin err_cnt++; $display("FAIL reset_din: got %0d, expected 0", din); end
        if (shot !== 1'b0)           begin err_cnt++; $display("FAIL reset_shot: got %b, expected 0", shot); end
        if (bullet_consume !== 1'b0) begin err_cnt++; $display("FAIL reset_consume: got %b, expected 0", bullet_consume); end
        if (hit_count !== 8'd0)      begin err_cnt++; $display("FAIL reset_hits: got %0d, expected 0", hit_count); end
        if (miss_count !== 8'd0)     begin err_cnt++; $display("FAIL reset_miss: got %0d, expected 0", miss_count); end
        rst_n  = 1'b1;
        enable = 1'b1;
        push_gap_entry();
    endtask

    task automatic test_launch();
        sb_launch(0);
    endtask

    task automatic test_handshake();
        for (int i = 0; i < 5; i++) begin
            tick();
            vec_cnt += 2;
            if (start !== 1'b1) begin err_cnt++; $display("FAIL hold_start: got %b, expected 1", start); end
            if (din !== cur_din) begin err_cnt++; $display("FAIL hold_din: got %0d, expected %0d", din, cur_din); end
        end
        fly();
    endtask

    task automatic test_hit();
        logic [9:0] xs [4] = '{10'd334, 10'd300, 10'd299, 10'd300};
        logic [8:0] ys [4] = '{9'd128, 9'd152, 9'd128, 9'd128};
        logic       es [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_bullet(1'b1, xs[i], ys[i]);
            shot_exp_q.push_back(es[i]);
            tick();
            sb_shot("hit_box");
        end
        exp_hits++;
        vec_cnt++;
        if (hit_count !== 8'(exp_hits)) begin err_cnt++; $display("FAIL hit_count1: got %0d, expected %0d", hit_count, exp_hits); end
        exit_target(1'b1);
        sb_launch(0);
        vec_cnt++;
        if (miss_count !== 8'(exp_miss)) begin err_cnt++; $display("FAIL miss_after_hit: got %0d, expected %0d", miss_count, exp_miss); end
        fly();
        drive_bullet(1'b1, 10'd333, 9'd151);
        shot_exp_q.push_back(1'b1);
        tick();
        sb_shot("hit_corner");
        exp_hits++;
        vec_cnt++;
        if (hit_count !== 8'(exp_hits)) begin err_cnt++; $display("FAIL hit_count2: got %0d, expected %0d", hit_count, exp_hits); end
        exit_target(1'b1);
        sb_launch(0);
    endtask

    task automatic test_lock();
        fly();
        drive_bullet(1'b1, 10'd310, 9'd130);
        for (int i = 0; i < 4; i++) shot_exp_q.push_back(i == 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            sb_shot("lock");
        end
        exp_hits++;
        vec_cnt++;
        if (hit_count !== 8'(exp_hits)) begin err_cnt++; $display("FAIL lock_hits: got %0d, expected %0d", hit_count, exp_hits); end
        exit_target(1'b1);
        sb_launch(0);
    endtask

    task automatic test_miss();
        fly();
        exit_target(1'b0);
        drive_bullet(1'b1, 10'd310, 9'd130);
        shot_exp_q.push_back(1'b0);
        tick();
        sb_shot("hit_on_exit");
        drive_bullet(1'b0, 10'd0, 9'd0);
        bump_miss();
        vec_cnt += 2;
        if (miss_count !== 8'(exp_miss)) begin err_cnt++; $display("FAIL miss_count: got %0d, expected %0d", miss_count, exp_miss); end
        if (hit_count !== 8'(exp_hits))  begin err_cnt++; $display("FAIL miss_hits: got %0d, expected %0d", hit_count, exp_hits); end
        sb_launch(1);
    endtask

    task automatic test_disable();
        fly();
        drive_bullet(1'b1, 10'd310, 9'd130);
        enable = 1'b0;
        shot_exp_q.push_back(1'b0);
        tick();
        sb_shot("disable_hit");
        drive_bullet(1'b0, 10'd0, 9'd0);
        repeat (3) tick();
        vec_cnt += 4;
        if (start !== 1'b0)              begin err_cnt++; $display("FAIL dis_start: got %b, expected 0", start); end
        if (din !== cur_din)             begin err_cnt++; $display("FAIL dis_din: got %0d, expected %0d", din, cur_din); end
        if (hit_count !== 8'(exp_hits))  begin err_cnt++; $display("FAIL dis_hits: got %0d, expected %0d", hit_count, exp_hits); end
        if (miss_count !== 8'(exp_miss)) begin err_cnt++; $display("FAIL dis_miss: got %0d, expected %0d", miss_count, exp_miss); end
        target_state = 2'd0;
        enable = 1'b1;
        push_gap_entry();
        sb_launch(0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            fly();
            exit_target(1'b0);
            bump_miss();
            sb_launch(0);
        end
        vec_cnt++;
        if (miss_count !== 8'(exp_miss)) begin err_cnt++; $display("FAIL miss_sat: got %0d, expected %0d", miss_count, exp_miss); end
        for (int i = 0; i < 256; i++) begin
            fly();
            drive_bullet(1'b1, 10'd320, 9'd140);
            shot_exp_q.push_back(1'b1);
            tick();
            sb_shot("sat_hit");
            if (exp_hits < 255) exp_hits++;
            exit_target(1'b1);
            sb_launch(0);
        end
        vec_cnt += 2;
        if (hit_count !== 8'(exp_hits))  begin err_cnt++; $display("FAIL hit_sat: got %0d, expected %0d", hit_count, exp_hits); end
        if (miss_count !== 8'(exp_miss)) begin err_cnt++; $display("FAIL miss_after_sat: got %0d, expected %0d", miss_count, exp_miss); end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        exp_hits = 0;
        exp_miss = 0;
        vec_cnt += 3;
        if (start !== 1'b0)      begin err_cnt++; $display("FAIL arst_start: got %b, expected 0", start); end
        if (hit_count !== 8'd0)  begin err_cnt++; $display("FAIL arst_hits: got %0d, expected 0", hit_count); end
        if (miss_count !== 8'd0) begin err_cnt++; $display("FAIL arst_miss: got %0d, expected 0", miss_count); end
        tick();
        rst_n = 1'b1;
        push_gap_entry();
        sb_launch(0);
    endtask

    initial begin
        test_reset();
        test_launch();
        test_handshake();
        test_hit();
        test_lock();
        test_miss();
        test_disable();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
